// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: loader state encodings, word geometry
// and default memory sizing.
package program_loader_pkg;

    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned CNT_W          = 2;
    localparam int unsigned LEN_WIDTH      = 16;
    localparam int unsigned DEF_MEM_WORDS  = 256;
    localparam int unsigned DEF_ADDR_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } ld_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Loader bus: byte stream in, instruction-memory write port out, CPU control/status out.
//   start, byte_in, byte_valid              : master -> loader
//   byte_ready, mem_we, mem_addr, mem_data  : loader -> master / memory
//   cpu_run, done, error                    : loader status
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  start;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data;
    logic                  cpu_run;
    logic                  done;
    logic                  error;

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_data, cpu_run, done, error
    );

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_data, cpu_run, done, error
    );
endinterface

// File: rtl/program_loader_packer.sv
// Byte packer: shifts bytes MSB-first into a 32-bit word, XOR-accumulates a checksum
// and flags the byte that completes a word.
//   clk, reset     : clock, async active-high reset
//   clear_i        : synchronous clear of word, byte count and checksum
//   shift_i        : accept byte_i this cycle
//   byte_i         : payload byte
//   word_o         : packed word (registered)
//   csum_o         : running XOR of accepted bytes (registered)
//   word_ready_c   : combinational, high when this shift completes a word
module program_loader_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [7:0]  csum_o,
    output logic        word_ready_c
);
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      word_q;
    logic [7:0]       csum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
            csum_q <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            word_q <= '0;
            csum_q <= '0;
        end else if (shift_i) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            word_q <= {word_q[23:0], byte_i};
            csum_q <= csum_q ^ byte_i;
        end
    end

    assign word_ready_c = shift_i && (cnt_q == CNT_W'(WORD_BYTES - 1));
    assign word_o       = word_q;
    assign csum_o       = csum_q;
endmodule

// File: rtl/program_loader.sv
// Program loader: parses LEN_HI, LEN_LO, payload, checksum; writes packed big-endian
// words to instruction memory and releases the CPU only after a clean checksum.
//   clk, reset : clock, async active-high reset
//   bus_io     : loader bus (stream in, memory write port, cpu_run/done/error)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned           MEM_WORDS  = DEF_MEM_WORDS,
    parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
)(
    input  logic              clk,
    input  logic              reset,
    program_loader_if.slave   bus_io
);
    ld_state_e             state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  word_cnt_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_we_q;
    logic                  byte_ready_q;
    logic                  cpu_run_q;
    logic                  done_q;
    logic                  error_q;

    logic                  transfer_c;
    logic                  restart_c;
    logic [LEN_WIDTH-1:0]  len_full_c;
    logic [LEN_WIDTH-1:0]  word_cnt_inc_c;
    logic [31:0]           word_c;
    logic [7:0]            csum_c;
    logic                  word_ready_c;

    assign transfer_c     = bus_io.byte_valid && byte_ready_q;
    // start is only honoured when no load is in progress
    assign restart_c      = bus_io.start &&
                            (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
    assign len_full_c     = {len_q[15:8], bus_io.byte_in};
    assign word_cnt_inc_c = word_cnt_q + LEN_WIDTH'(1);

    program_loader_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (restart_c),
        .shift_i      (transfer_c && (state_q == ST_DATA)),
        .byte_i       (bus_io.byte_in),
        .word_o       (word_c),
        .csum_o       (csum_c),
        .word_ready_c (word_ready_c)
    );

    // Loader FSM; outputs are set on the transition so they are valid on state entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            mem_addr_q   <= BASE_ADDR;
            mem_we_q     <= 1'b0;
            byte_ready_q <= 1'b0;
            cpu_run_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (restart_c) begin
                        state_q      <= ST_LEN_HI;
                        byte_ready_q <= 1'b1;
                        len_q        <= '0;
                        word_cnt_q   <= '0;
                        mem_addr_q   <= BASE_ADDR;
                        cpu_run_q    <= 1'b0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                    end
                end
                ST_LEN_HI: begin
                    if (transfer_c) begin
                        len_q[15:8] <= bus_io.byte_in;
                        state_q     <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (transfer_c) begin
                        len_q[7:0] <= bus_io.byte_in;
                        if (len_full_c > LEN_WIDTH'(MEM_WORDS)) begin
                            state_q      <= ST_ERROR;
                            byte_ready_q <= 1'b0;
                            error_q      <= 1'b1;
                        end else if (len_full_c == '0) begin
                            state_q <= ST_CHECK;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_ready_c) begin
                        state_q      <= ST_WRITE;
                        byte_ready_q <= 1'b0;
                        mem_we_q     <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    mem_addr_q   <= mem_addr_q + ADDR_WIDTH'(WORD_BYTES);
                    word_cnt_q   <= word_cnt_inc_c;
                    byte_ready_q <= 1'b1;
                    state_q      <= (word_cnt_inc_c == len_q) ? ST_CHECK : ST_DATA;
                end
                ST_CHECK: begin
                    if (transfer_c) begin
                        byte_ready_q <= 1'b0;
                        if (bus_io.byte_in == csum_c) begin
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            cpu_run_q <= 1'b1;
                        end else begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_io.byte_ready = byte_ready_q;
    assign bus_io.mem_we     = mem_we_q;
    assign bus_io.mem_addr   = mem_addr_q;
    assign bus_io.mem_data   = word_c;
    assign bus_io.cpu_run    = cpu_run_q;
    assign bus_io.done       = done_q;
    assign bus_io.error      = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized images
// checked against a write-list/status model computed from the stream format rules.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_loader dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus.slave)
    );

    // Every observed memory write as {addr, data}
    logic [AW+31:0] wlog[$];
    always @(negedge clk) if (bus.mem_we === 1'b1) wlog.push_back({bus.mem_addr, bus.mem_data});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Offer one byte; returns #1 after the edge on which it was accepted
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int   waitc;
        logic r;
        if (gaps && $urandom_range(0, 2) == 0) begin
            bus.byte_valid = 1'b0;
            bus.byte_in    = 8'($urandom);
            repeat ($urandom_range(1, 3)) tick();
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        waitc = 0;
        forever begin
            @(negedge clk);
            r = bus.byte_ready;
            @(posedge clk);
            if (r === 1'b1) break;
            waitc++;
            if (waitc > 20) begin
                checks++; failures++;
                $display("FAIL send_byte_timeout byte=%02h byte_ready stayed %b, required 1", b, r);
                break;
            end
        end
        #1;
    endtask

    // Stream one image and compare status and write list with the model
    task automatic run_image(input string name, input logic [15:0] n, input logic [7:0] pay[$],
                             input logic [7:0] csum, input bit gaps, input bit start_noise);
        logic [7:0]     x;
        bit             len_ok;
        bit             exp_done;
        int             exp_n;
        logic [AW+31:0] exp_w;
        len_ok = (n <= 16'(DEF_MEM_WORDS));
        x = 8'h00;
        foreach (pay[i]) x ^= pay[i];
        exp_done = len_ok && (x == csum);
        exp_n    = len_ok ? int'(n) : 0;

        wlog.delete();
        pulse_start();
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        if (len_ok) begin
            for (int i = 0; i < 4 * int'(n); i++) begin
                if (start_noise && i == 2) bus.start = 1'b1;
                send_byte(pay[i], gaps);
                bus.start = 1'b0;
            end
            send_byte(csum, gaps);
        end
        bus.byte_valid = 1'b0;
        tick();
        tick();

        checks++;
        if (bus.done !== exp_done) begin
            failures++; $display("FAIL %s done=%b required %b", name, bus.done, exp_done);
        end
        checks++;
        if (bus.error !== !exp_done) begin
            failures++; $display("FAIL %s error=%b required %b", name, bus.error, !exp_done);
        end
        checks++;
        if (bus.cpu_run !== exp_done) begin
            failures++; $display("FAIL %s cpu_run=%b required %b", name, bus.cpu_run, exp_done);
        end
        checks++;
        if (bus.byte_ready !== 1'b0) begin
            failures++; $display("FAIL %s byte_ready=%b required 0", name, bus.byte_ready);
        end
        checks++;
        if (wlog.size() != exp_n) begin
            failures++; $display("FAIL %s write_count=%0d required %0d", name, wlog.size(), exp_n);
        end
        for (int i = 0; i < wlog.size() && i < exp_n; i++) begin
            exp_w = {AW'(4 * i), pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]};
            checks++;
            if (wlog[i] !== exp_w) begin
                failures++;
                $display("FAIL %s write[%0d] addr/data=%h required %h", name, i, wlog[i], exp_w);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.byte_ready, bus.mem_we, bus.cpu_run, bus.done, bus.error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags ready/we/run/done/err=%b required 00000",
                     {bus.byte_ready, bus.mem_we, bus.cpu_run, bus.done, bus.error});
        end
        checks++;
        if (bus.mem_addr !== AW'(0) || bus.mem_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus addr=%h data=%h required 000 00000000", bus.mem_addr, bus.mem_data);
        end
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.byte_ready !== 1'b0) begin
            failures++; $display("FAIL idle_ready byte_ready=%b required 0", bus.byte_ready);
        end
    endtask

    // Directed image with latency checks; payload XOR is 0x8D
    task automatic test_happy();
        logic [7:0] img[$] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
        wlog.delete();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 4; i++) send_byte(img[4*w+i], 1'b0);
            checks++;
            if (bus.mem_we !== 1'b1 || bus.byte_ready !== 1'b0) begin
                failures++;
                $display("FAIL happy_strobe%0d we=%b ready=%b required we=1 ready=0",
                         w, bus.mem_we, bus.byte_ready);
            end
            checks++;
            if (bus.mem_addr !== AW'(4 * w) ||
                bus.mem_data !== {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]}) begin
                failures++;
                $display("FAIL happy_word%0d addr=%h data=%h required %h %h", w, bus.mem_addr,
                         bus.mem_data, AW'(4 * w), {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]});
            end
        end
        send_byte(8'h8D, 1'b0);
        bus.byte_valid = 1'b0;
        checks++;
        if ({bus.cpu_run, bus.done, bus.error} !== 3'b110) begin
            failures++;
            $display("FAIL happy_release run/done/err=%b required 110", {bus.cpu_run, bus.done, bus.error});
        end
        checks++;
        if (wlog.size() != 2) begin
            failures++; $display("FAIL happy_write_count=%0d required 2", wlog.size());
        end
    endtask

    task automatic test_errors();
        logic [7:0] img[$] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
        logic [7:0] none[$];
        run_image("bad_csum_80", 16'h0002, img, 8'h80, 1'b0, 1'b0);
        run_image("bad_csum_81", 16'h0002, img, 8'h81, 1'b0, 1'b0);
        run_image("overflow",    16'h0101, none, 8'h00, 1'b0, 1'b0);
        run_image("empty_ok",    16'h0000, none, 8'h00, 1'b0, 1'b0);
        run_image("empty_bad",   16'h0000, none, 8'h01, 1'b0, 1'b0);
    endtask

    // Restart from DONE drops cpu_run on the next cycle, then loads again
    task automatic test_back_to_back();
        logic [7:0] img[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_image("b2b_first", 16'h0001, img, 8'h44, 1'b0, 1'b0);
        pulse_start();
        checks++;
        if ({bus.cpu_run, bus.done, bus.byte_ready} !== 3'b001) begin
            failures++;
            $display("FAIL restart_drop run/done/ready=%b required 001",
                     {bus.cpu_run, bus.done, bus.byte_ready});
        end
        run_image("b2b_second", 16'h0001, img, 8'h44, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0]  pay[$];
        logic [7:0]  x;
        logic [15:0] n;
        for (int t = 0; t < 7; t++) begin
            n = (t == 6) ? 16'(DEF_MEM_WORDS) : 16'($urandom_range(1, 6));
            pay.delete();
            x = 8'h00;
            for (int i = 0; i < 4 * int'(n); i++) begin
                pay.push_back(8'($urandom));
                x ^= pay[i];
            end
            if (t != 6 && $urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
            run_image($sformatf("random%0d", t), n, pay, x, (t != 6), (t % 2 == 1));
        end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] img[$] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        int         nw;
        wlog.delete();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(img[i], 1'b0);
        nw = wlog.size();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.byte_ready, bus.mem_we, bus.cpu_run, bus.done, bus.error} !== 5'b0 ||
            bus.mem_addr !== AW'(0) || bus.mem_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid flags=%b addr=%h data=%h required 00000 000 00000000",
                     {bus.byte_ready, bus.mem_we, bus.cpu_run, bus.done, bus.error},
                     bus.mem_addr, bus.mem_data);
        end
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        bus.byte_valid = 1'b0;
        tick();
        checks++;
        if (wlog.size() != nw || nw != 1) begin
            failures++; $display("FAIL reset_mid_writes=%0d required 1", wlog.size());
        end
        run_image("after_reset", 16'h0002, img, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04,
                  1'b1, 1'b0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        test_reset();
        test_happy();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
